fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_perf_cnt.sv | 32 +++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM encodings and
// the branch, reset and write-enable active levels.
package fetch_ctrl_pkg;

   localparam logic [1:0] FETCH_IDLE    = 2'd0;
   localparam logic [1:0] FETCH_ISSUE   = 2'd1;
   localparam logic [1:0] FETCH_WAIT    = 2'd2;
   localparam logic [1:0] FETCH_DISCARD = 2'd3;

   localparam logic BRANCH_TAKEN = 1'b1;
   localparam logic RST_ACTIVE   = 1'b1;
   localparam logic WE_ACTIVE    = 1'b1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory request/response bus and the IF/ID output
// register handshake. master = fetch_ctrl side, slave = memory/decode side.
interface fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);

   logic              imem_req_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic              imem_ack_i;
   logic [INST_W-1:0] imem_data_i;
   logic              if_valid_o;
   logic [ADDR_W-1:0] if_pc_o;
   logic [INST_W-1:0] if_inst_o;
   logic              id_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
      input  imem_ack_i, imem_data_i, id_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
      output imem_ack_i, imem_data_i, id_ready_i
   );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter used by fetch_ctrl's optional perf
// counters (FETCH_CTRL_PERF_EN).
module fetch_perf_cnt
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_d;
   logic [31:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem read,
// holds the result for decode and redirects on branches.
// Optional perf counters are enabled with the FETCH_CTRL_PERF_EN macro.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] pc_o,
`ifdef FETCH_CTRL_PERF_EN
   output logic [31:0]       perf_stall_cnt_o,
   output logic [31:0]       perf_flush_cnt_o,
`endif
   fetch_ctrl_if.master      bus
);

   logic [1:0]        state_d, state_q;
   logic [ADDR_W-1:0] pc_d, pc_q;
   logic              valid_d, valid_q;
   logic [ADDR_W-1:0] if_pc_d, if_pc_q;
   logic [INST_W-1:0] if_inst_d, if_inst_q;
   logic              slot_free;
   logic              branch_taken;
   logic              load_we;

   assign branch_taken = (branch_i == BRANCH_TAKEN);

   always_comb begin
      slot_free       = !valid_q || bus.id_ready_i;
      bus.imem_req_o  = (state_q == FETCH_ISSUE) && slot_free && !branch_taken;
      bus.imem_addr_o = pc_q;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      if_pc_d   = if_pc_q;
      if_inst_d = if_inst_q;
      load_we   = !WE_ACTIVE;

      case (state_q)
         FETCH_IDLE:    state_d = FETCH_ISSUE;
         FETCH_ISSUE:   if (bus.imem_req_o) state_d = FETCH_WAIT;
         FETCH_WAIT: begin
            if (bus.imem_ack_i) begin
               state_d = FETCH_ISSUE;
               if (!branch_taken) load_we = WE_ACTIVE;
            end
         end
         FETCH_DISCARD: if (bus.imem_ack_i) state_d = FETCH_ISSUE;
         default:       state_d = FETCH_IDLE;
      endcase

      if (load_we == WE_ACTIVE) begin
         if_inst_d = bus.imem_data_i;
         if_pc_d   = pc_q;
         valid_d   = 1'b1;
         pc_d      = pc_q + ADDR_W'(4);
      end else if (valid_q && bus.id_ready_i) begin
         valid_d = 1'b0;
      end

      // A redirect drops the held instruction and any fetch still in flight.
      if (branch_taken) begin
         pc_d    = branch_target_i & ~ADDR_W'(3);
         valid_d = 1'b0;
         if ((state_q == FETCH_WAIT) && !bus.imem_ack_i) begin
            state_d = FETCH_DISCARD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         state_q   <= FETCH_IDLE;
         pc_q      <= RESET_ADDR;
         valid_q   <= 1'b0;
         if_pc_q   <= '0;
         if_inst_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         if_pc_q   <= if_pc_d;
         if_inst_q <= if_inst_d;
      end
   end

   assign pc_o           = pc_q;
   assign bus.if_valid_o = valid_q;
   assign bus.if_pc_o    = if_pc_q;
   assign bus.if_inst_o  = if_inst_q;

`ifdef FETCH_CTRL_PERF_EN
   logic stall_evt;

   assign stall_evt = (state_q == FETCH_ISSUE) && !slot_free;

   fetch_perf_cnt u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_evt),
      .cnt_o (perf_stall_cnt_o)
   );

   fetch_perf_cnt u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (branch_taken),
      .cnt_o (perf_flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a latency-programmable imem model plus
// a scoreboard of fetched {pc, inst} pairs checked as decode accepts them.
module tb_fetch_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic [31:0] pc_o;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt_o;
   logic [31:0] perf_flush_cnt_o;
`endif

   int          tests_run = 0;
   int          tests_failed = 0;
   sb_t         sb_q[$];
   logic [31:0] exp_fetch_pc = 32'h0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;
   int          req_cnt = 0;
   int          branches_driven = 0;

   fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

   fetch_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .branch_i         (branch_i),
      .branch_target_i  (branch_target_i),
      .pc_o             (pc_o),
`ifdef FETCH_CTRL_PERF_EN
      .perf_stall_cnt_o (perf_stall_cnt_o),
      .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
      .bus              (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[31:16], a[15:0] ^ 16'h5A5A};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge; a branch retires
   // every queued fetch except an instruction decode takes at this same edge.
   task automatic applyStimulus(input logic br, input logic [31:0] target,
                                input logic ready);
      @(posedge clk);
      #1;
      bus.id_ready_i  = ready;
      branch_i        = br;
      branch_target_i = target;
      if (br) begin
         branches_driven++;
         if (bus.if_valid_o && ready && sb_q.size() > 0) begin
            while (sb_q.size() > 1) void'(sb_q.pop_back());
         end else begin
            sb_q.delete();
         end
         exp_fetch_pc = target & ~32'h3;
      end
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic waitReq(input string tag, input int max_cycles);
      int  start;
      logic seen;
      start = req_cnt;
      seen  = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         sampleCycle();
         if (req_cnt != start) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   // Instruction memory model and scoreboard monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      bus.imem_ack_i = 1'b0;
      if (rst) begin
         mem_cnt = 0;
      end else begin
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               bus.imem_ack_i  = 1'b1;
               bus.imem_data_i = mem_word(mem_addr);
            end
         end
         if (bus.imem_req_o) begin
            req_cnt++;
            checkOutput("one_outstanding", 32'(mem_cnt), 32'd0);
            checkOutput("req_addr", bus.imem_addr_o, exp_fetch_pc);
            sb_q.push_back('{pc: bus.imem_addr_o, inst: mem_word(bus.imem_addr_o)});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            mem_addr = bus.imem_addr_o;
            mem_cnt  = mem_lat;
         end
         if (bus.if_valid_o && bus.id_ready_i) begin
            checkOutput("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               sb_t e;
               e = sb_q.pop_front();
               checkOutput("if_pc", bus.if_pc_o, e.pc);
               checkOutput("if_inst", bus.if_inst_o, e.inst);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          start;
      int          n;
      logic [31:0] snap_inst;
`ifdef FETCH_CTRL_PERF_EN
      logic [31:0] snap_stall;
`endif
      rst             = 1'b1;
      branch_i        = 1'b0;
      branch_target_i = 32'h0;
      bus.id_ready_i  = 1'b1;

      // Reset values.
      sampleCycle();
      sampleCycle();
      checkOutput("rst_req", 32'(bus.imem_req_o), 32'd0);
      checkOutput("rst_addr", bus.imem_addr_o, 32'h0);
      checkOutput("rst_pc", pc_o, 32'h0);
      checkOutput("rst_valid", 32'(bus.if_valid_o), 32'd0);
      checkOutput("rst_if_pc", bus.if_pc_o, 32'h0);
      checkOutput("rst_if_inst", bus.if_inst_o, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
      checkOutput("rst_stall_cnt", perf_stall_cnt_o, 32'h0);
      checkOutput("rst_flush_cnt", perf_flush_cnt_o, 32'h0);
`endif

      // Reset release, k=1, decode always ready.
      mem_lat = 1;
      @(posedge clk);
      #1 rst = 1'b0;
      sampleCycle();
      checkOutput("first_req_c1", 32'(bus.imem_req_o), 32'd0);
      sampleCycle();
      checkOutput("first_req_c2", 32'(bus.imem_req_o), 32'd1);
      checkOutput("first_req_addr", bus.imem_addr_o, 32'h0);
      start = req_cnt;
      for (int i = 0; i < 8; i++) sampleCycle();
      checkOutput("throughput_k1", 32'(req_cnt - start), 32'd4);

      // Decode stalls for 5 cycles with an instruction held.
      applyStimulus(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) sampleCycle();
      snap_inst = bus.if_inst_o;
`ifdef FETCH_CTRL_PERF_EN
      snap_stall = perf_stall_cnt_o;
`endif
      for (int i = 0; i < 5; i++) begin
         sampleCycle();
         checkOutput("stall_req", 32'(bus.imem_req_o), 32'd0);
         checkOutput("stall_valid", 32'(bus.if_valid_o), 32'd1);
         checkOutput("stall_inst", bus.if_inst_o, snap_inst);
      end
`ifdef FETCH_CTRL_PERF_EN
      checkOutput("stall_cnt", perf_stall_cnt_o - snap_stall, 32'd5);
`endif
      applyStimulus(1'b0, 32'h0, 1'b1);

      // Branch to 0x23 while waiting on a k=3 fetch.
      mem_lat = 3;
      waitReq("t3_req_timeout", 20);
      applyStimulus(1'b1, 32'h23, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         sampleCycle();
         n++;
         checkOutput("discard_valid", 32'(bus.if_valid_o), 32'd0);
         if (bus.imem_req_o) break;
      end
      checkOutput("discard_cycles", 32'(n), 32'd3);
      checkOutput("discard_new_addr", bus.imem_addr_o, 32'h20);

      // Branch coinciding with an ack, k=2.
      mem_lat = 2;
      waitReq("t4_req_timeout", 20);
      @(posedge clk);
      applyStimulus(1'b1, 32'h100, 1'b1);
      sampleCycle();
      checkOutput("ack_align", 32'(bus.imem_ack_i), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      sampleCycle();
      checkOutput("ackbr_valid", 32'(bus.if_valid_o), 32'd0);
      checkOutput("ackbr_pc", pc_o, 32'h100);
      checkOutput("ackbr_req", 32'(bus.imem_req_o), 32'd1);
      checkOutput("ackbr_addr", bus.imem_addr_o, 32'h100);

      // PC wrap at the top of the address space.
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      n = 0;
      while (n < 20 && !bus.if_valid_o) begin
         sampleCycle();
         n++;
      end
      checkOutput("wrap_valid", 32'(bus.if_valid_o), 32'd1);
      checkOutput("wrap_if_pc", bus.if_pc_o, 32'hFFFF_FFFC);
      checkOutput("wrap_pc", pc_o, 32'h0);
      sampleCycle();
`ifdef FETCH_CTRL_PERF_EN
      checkOutput("flush_cnt", perf_flush_cnt_o, 32'(branches_driven));
`endif

      // Reset while a k=3 fetch is outstanding.
      mem_lat = 3;
      waitReq("t6_req_timeout", 20);
      @(posedge clk);
      #1 rst = 1'b1;
      sb_q.delete();
      exp_fetch_pc = 32'h0;
      #1;
      checkOutput("midrst_req", 32'(bus.imem_req_o), 32'd0);
      checkOutput("midrst_addr", bus.imem_addr_o, 32'h0);
      checkOutput("midrst_pc", pc_o, 32'h0);
      checkOutput("midrst_valid", 32'(bus.if_valid_o), 32'd0);
      checkOutput("midrst_if_pc", bus.if_pc_o, 32'h0);
      checkOutput("midrst_if_inst", bus.if_inst_o, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      mem_lat = 1;
      waitReq("restart_timeout", 5);
      checkOutput("restart_addr", bus.imem_addr_o, 32'h0);
      for (int i = 0; i < 6; i++) sampleCycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
